pr_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the processor-side device bus (PrAddr/BE/PrWD/PrRD) that feeds the device bridge (timer, LED, switch).
- Master 0 is the CPU data port; master 1 is a DMA/debug master.
- Grants one master at a time, drives a device access of fixed length, captures read data and returns a one-cycle ack.
- Arbitration between the two masters is round-robin.

---
 rtl/pr_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_pr_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter
//   Two-master arbiter and sequencer for the processor-side device bus
//   (PrAddr/BE/PrWD/PrRD) that feeds the device bridge. Master 0 is the CPU
//   data port and master 1 is a DMA/debug master. One master owns the bus at a
//   time. Each access holds the bus for WAIT_CYCLES cycles, captures read data
//   and returns a one-cycle ack to the owner.
//
//   Build option: define ARB_CPU_PRIORITY_EN for fixed priority (m0 always
//   wins). Without it, arbitration is round-robin.
//
//   Parameter:
//     WAIT_CYCLES  bus cycles per access, 1..15. A value of 0 behaves as 1.
//
//   Ports:
//     clk, rst                   clock (rising edge), synchronous active-high reset
//     mN_req/we/addr/be/wd       master N request and its fields, held until mN_ack
//     mN_rd, mN_ack              master N read data and completion pulse
//     PrAddr, BE, PrWD           bus address, byte enables (0 = read/idle), write data
//     PrRD                       bus read data from the bridge
//     grant                      one-hot bus owner (bit0 = m0, bit1 = m1), 00 = idle
//     busy                       high while an access is in ACCESS or DONE
module pr_bus_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [29:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wd,
    output logic [31:0] m0_rd,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [29:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wd,
    output logic [31:0] m1_rd,
    output logic        m1_ack,
    output logic [29:0] PrAddr,
    output logic [3:0]  BE,
    output logic [31:0] PrWD,
    input  logic [31:0] PrRD,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The access counter is 4 bits wide, so the cycle count is clamped to 1..15.
    localparam int         WC_EFF   = (WAIT_CYCLES < 1)  ? 1  :
                                      (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
    localparam logic [3:0] CNT_LOAD = 4'(WC_EFF - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        last_m1_q;     // 1: master 1 owned the bus most recently
    logic        we_q;
    logic [29:0] pr_addr_q;
    logic [3:0]  be_q;
    logic [31:0] pr_wd_q;
    logic [1:0]  grant_q;
    logic        busy_q;
    logic [31:0] m0_rd_q, m1_rd_q;
    logic        m0_ack_q, m1_ack_q;

    // Winner selection. This value is used only when a request is sampled in IDLE.
    logic        any_req_d;
    logic        win_m1_d;
    logic        sel_we_d;
    logic [29:0] sel_addr_d;
    logic [3:0]  sel_be_d;
    logic [31:0] sel_wd_d;

    assign any_req_d = m0_req | m1_req;
`ifdef ARB_CPU_PRIORITY_EN
    assign win_m1_d  = m1_req & ~m0_req;
`else
    // On a tie, grant the master that did not own the bus last.
    assign win_m1_d  = m1_req & (~m0_req | ~last_m1_q);
`endif
    assign sel_we_d   = win_m1_d ? m1_we   : m0_we;
    assign sel_addr_d = win_m1_d ? m1_addr : m0_addr;
    assign sel_be_d   = win_m1_d ? m1_be   : m0_be;
    assign sel_wd_d   = win_m1_d ? m1_wd   : m0_wd;

    // NOTE: every register here uses non-blocking assignment. All state then
    // updates from the same pre-edge values, and the block order does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_m1_q <= 1'b1;      // m0 wins the first tie after reset
            we_q      <= 1'b0;
            pr_addr_q <= '0;
            be_q      <= 4'd0;
            pr_wd_q   <= '0;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            // NOTE: the read-data registers are reset as well, so a reset in
            // mid-access cannot leave stale data visible to either master.
            m0_rd_q   <= '0;
            m1_rd_q   <= '0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        pr_addr_q <= sel_addr_d;
                        pr_wd_q   <= sel_wd_d;
                        we_q      <= sel_we_d;
                        // The bridge write-enables from BE, so it is driven only
                        // in the first ACCESS cycle of a write.
                        be_q      <= sel_we_d ? sel_be_d : 4'd0;
                        grant_q   <= win_m1_d ? 2'b10 : 2'b01;
                        last_m1_q <= win_m1_d;
                        cnt_q     <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    be_q <= 4'd0;
                    if (cnt_q == 4'd0) begin
                        if (!we_q) begin
                            if (grant_q[1]) m1_rd_q <= PrRD;
                            else            m0_rd_q <= PrRD;
                        end
                        m0_ack_q <= grant_q[0];
                        m1_ack_q <= grant_q[1];
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    m0_ack_q  <= 1'b0;
                    m1_ack_q  <= 1'b0;
                    grant_q   <= 2'b00;
                    busy_q    <= 1'b0;
                    we_q      <= 1'b0;
                    pr_addr_q <= '0;
                    pr_wd_q   <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PrAddr = pr_addr_q;
    assign BE     = be_q;
    assign PrWD   = pr_wd_q;
    assign grant  = grant_q;
    assign busy   = busy_q;
    assign m0_rd  = m0_rd_q;
    assign m1_rd  = m1_rd_q;
    assign m0_ack = m0_ack_q;
    assign m1_ack = m1_ack_q;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Testbench for pr_bus_arbiter. Three instances run with WAIT_CYCLES = 1, 3 and 4.
// Each expected ack is queued when its request is driven. The monitor pops the
// queue when an ack appears and compares the source master and the read data.
module tb_pr_bus_arbiter;

    localparam int N = 3;

    logic        clk;
    logic        rst     [N];
    logic        m0_req  [N];
    logic        m0_we   [N];
    logic [29:0] m0_addr [N];
    logic [3:0]  m0_be   [N];
    logic [31:0] m0_wd   [N];
    logic [31:0] m0_rd   [N];
    logic        m0_ack  [N];
    logic        m1_req  [N];
    logic        m1_we   [N];
    logic [29:0] m1_addr [N];
    logic [3:0]  m1_be   [N];
    logic [31:0] m1_wd   [N];
    logic [31:0] m1_rd   [N];
    logic        m1_ack  [N];
    logic [29:0] pr_addr [N];
    logic [3:0]  be      [N];
    logic [31:0] pr_wd   [N];
    logic [31:0] pr_rd   [N];
    logic [1:0]  grant   [N];
    logic        busy    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        pr_bus_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
            .clk    (clk),
            .rst    (rst[g]),
            .m0_req (m0_req[g]),
            .m0_we  (m0_we[g]),
            .m0_addr(m0_addr[g]),
            .m0_be  (m0_be[g]),
            .m0_wd  (m0_wd[g]),
            .m0_rd  (m0_rd[g]),
            .m0_ack (m0_ack[g]),
            .m1_req (m1_req[g]),
            .m1_we  (m1_we[g]),
            .m1_addr(m1_addr[g]),
            .m1_be  (m1_be[g]),
            .m1_wd  (m1_wd[g]),
            .m1_rd  (m1_rd[g]),
            .m1_ack (m1_ack[g]),
            .PrAddr (pr_addr[g]),
            .BE     (be[g]),
            .PrWD   (pr_wd[g]),
            .PrRD   (pr_rd[g]),
            .grant  (grant[g]),
            .busy   (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          dut;
        bit          m1;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   ack_cnt [N];
    int   be_cnt  [N];

    initial begin
        for (int d = 0; d < N; d++) begin
            ack_cnt[d] = 0;
            be_cnt[d]  = 0;
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (be[d] !== 4'd0) be_cnt[d]++;
            if (m0_ack[d] === 1'b1 || m1_ack[d] === 1'b1) begin
                ack_cnt[d]++;
                if (sb_q.size() == 0) begin
                    check("ack_unexpected", {m1_ack[d], m0_ack[d]}, 2'b00);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("ack_dut", d, e.dut);
                    check("ack_src", {m1_ack[d], m0_ack[d]}, e.m1 ? 2'b10 : 2'b01);
                    if (e.chk_rd) check("ack_rd", e.m1 ? m1_rd[d] : m0_rd[d], e.rd);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input bit m, input bit we, input logic [29:0] a,
                         input logic [3:0] b, input logic [31:0] wd);
        if (m) begin
            m1_req[d] = 1'b1; m1_we[d] = we; m1_addr[d] = a; m1_be[d] = b; m1_wd[d] = wd;
        end else begin
            m0_req[d] = 1'b1; m0_we[d] = we; m0_addr[d] = a; m0_be[d] = b; m0_wd[d] = wd;
        end
    endtask

    task automatic drop(input int d, input bit m);
        if (m) m1_req[d] = 1'b0;
        else   m0_req[d] = 1'b0;
    endtask

    task automatic expect_ack(input int d, input bit m, input bit chk, input logic [31:0] rd);
        exp_t e;
        e.dut = d; e.m1 = m; e.chk_rd = chk; e.rd = rd;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) step();
        check("sb_drain", sb_q.size(), 0);
    endtask

    // Waits for one ack from instance d, then drops that master's request.
    task automatic wait_ack_drop(input int d, input bit m, input int budget);
        int base;
        base = ack_cnt[d];
        for (int i = 0; i < budget && ack_cnt[d] == base; i++) step();
        drop(d, m);
        check("ack_wait", ack_cnt[d] - base, 1);
    endtask

    task automatic reset_all();
        for (int d = 0; d < N; d++) rst[d] = 1'b1;
        step();
        step();
        for (int d = 0; d < N; d++) rst[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int cyc;
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1;
            m0_req[d] = 0; m0_we[d] = 0; m0_addr[d] = '0; m0_be[d] = '0; m0_wd[d] = '0;
            m1_req[d] = 0; m1_we[d] = 0; m1_addr[d] = '0; m1_be[d] = '0; m1_wd[d] = '0;
            pr_rd[d] = '0;
        end
        reset_all();

        // Reset state on every instance.
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check("rst_praddr", pr_addr[d], 30'h0);
            check("rst_be_prwd", {be[d], pr_wd[d]}, 36'h0);
            check("rst_grant_busy", {grant[d], busy[d]}, 3'b000);
            check("rst_acks", {m1_ack[d], m0_ack[d]}, 2'b00);
            check("rst_rd", {m1_rd[d], m0_rd[d]}, 64'h0);
        end

        // Test 1: WAIT_CYCLES=1, m0 write.
        step();
        issue(0, 0, 1, 30'h1FC1, 4'hF, 32'h0000_00FF);
        expect_ack(0, 0, 0, 32'h0);
        step();
        @(negedge clk);
        check("t1_praddr", pr_addr[0], 30'h1FC1);
        check("t1_be", be[0], 4'hF);
        check("t1_prwd", pr_wd[0], 32'h0000_00FF);
        check("t1_grant", grant[0], 2'b01);
        check("t1_busy", busy[0], 1'b1);
        step();
        drop(0, 0);
        @(negedge clk);
        check("t1_done_ack", {m1_ack[0], m0_ack[0]}, 2'b01);
        check("t1_done_be", be[0], 4'h0);
        check("t1_done_addr", pr_addr[0], 30'h1FC1);
        step();
        @(negedge clk);
        check("t1_idle", {grant[0], busy[0], m0_ack[0]}, 4'b0000);
        wait_drain(5);

        // Test 2: WAIT_CYCLES=3, m1 read. PrRD changes every cycle, so only a
        // capture in the last ACCESS cycle returns 0003.
        step();
        issue(1, 1, 0, 30'h1FC8, 4'h0, 32'h0);
        expect_ack(1, 1, 1, 32'hA5A5_0003);
        step();
        for (int k = 1; k <= 3; k++) begin
            pr_rd[1] = 32'hA5A5_0000 | 32'(k);
            @(negedge clk);
            check("t2_be", be[1], 4'h0);
            check("t2_grant", grant[1], 2'b10);
            check("t2_addr", pr_addr[1], 30'h1FC8);
            check("t2_noack", {m1_ack[1], m0_ack[1]}, 2'b00);
            step();
        end
        drop(1, 1);
        pr_rd[1] = 32'h0;
        @(negedge clk);
        check("t2_ack", {m1_ack[1], m0_ack[1]}, 2'b10);
        check("t2_m1_rd", m1_rd[1], 32'hA5A5_0003);
        check("t2_m0_rd", m0_rd[1], 32'h0);
        wait_drain(5);

        // Test 3: both masters request continuously for four transactions from reset.
        reset_all();
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_CPU_PRIORITY_EN
            expect_ack(0, 0, 0, 32'h0);
`else
            expect_ack(0, (i % 2) == 1, 0, 32'h0);
`endif
        end
        issue(0, 0, 0, 30'h0100, 4'h0, 32'h0);
        issue(0, 1, 0, 30'h0200, 4'h0, 32'h0);
        base = ack_cnt[0];
        cyc = 0;
        for (int i = 1; i <= 40 && cyc == 0; i++) begin
            step();
            if (ack_cnt[0] - base >= 4) cyc = i;
        end
        drop(0, 0);
        drop(0, 1);
        check("t3_count", ack_cnt[0] - base, 4);
        check("t3_cycles", cyc, 12);
        wait_drain(5);

        // Test 4: m1 requests while m0 is in ACCESS, so m1 waits for the next IDLE.
        step();
        step();
        issue(0, 0, 1, 30'h0010, 4'hF, 32'hDEAD_BEEF);
        expect_ack(0, 0, 0, 32'h0);
        step();
        issue(0, 1, 0, 30'h0020, 4'h0, 32'h0);
        pr_rd[0] = 32'h1234_5678;
        expect_ack(0, 1, 1, 32'h1234_5678);
        @(negedge clk);
        check("t4_acc_grant", grant[0], 2'b01);
        step();
        drop(0, 0);
        @(negedge clk);
        check("t4_m0_ack", {m1_ack[0], m0_ack[0]}, 2'b01);
        step();
        @(negedge clk);
        check("t4_idle", {grant[0], m1_ack[0], m0_ack[0]}, 4'b0000);
        step();
        @(negedge clk);
        check("t4_m1_access", {grant[0], m1_ack[0], m0_ack[0]}, 4'b1000);
        step();
        drop(0, 1);
        @(negedge clk);
        check("t4_m1_ack", {m1_ack[0], m0_ack[0]}, 2'b10);
        wait_drain(5);

        // Test 5: WAIT_CYCLES=4. A read loads m1_rd, then a write is reset in
        // its second ACCESS cycle.
        step();
        issue(2, 1, 0, 30'h0005, 4'h0, 32'h0);
        pr_rd[2] = 32'hCAFE_0005;
        expect_ack(2, 1, 1, 32'hCAFE_0005);
        wait_ack_drop(2, 1, 20);
        wait_drain(2);
        base = be_cnt[2];
        issue(2, 0, 1, 30'h1FC4, 4'h3, 32'h0000_00AA);
        step();
        @(negedge clk);
        check("t5_be_first", be[2], 4'h3);
        step();
        rst[2] = 1'b1;
        @(negedge clk);
        check("t5_be_second", be[2], 4'h0);
        check("t5_busy", busy[2], 1'b1);
        step();
        rst[2] = 1'b0;
        drop(2, 0);
        @(negedge clk);
        check("t5_praddr", pr_addr[2], 30'h0);
        check("t5_be_prwd", {be[2], pr_wd[2]}, 36'h0);
        check("t5_grant_busy", {grant[2], busy[2]}, 3'b000);
        check("t5_acks", {m1_ack[2], m0_ack[2]}, 2'b00);
        check("t5_rd", {m1_rd[2], m0_rd[2]}, 64'h0);
        repeat (8) step();
        check("t5_be_pulses", be_cnt[2] - base, 1);

        // Test 6: m0 read with req dropped in the first ACCESS cycle.
        issue(0, 0, 0, 30'h0030, 4'h0, 32'h0);
        pr_rd[0] = 32'h0BAD_F00D;
        expect_ack(0, 0, 1, 32'h0BAD_F00D);
        base = ack_cnt[0];
        step();
        drop(0, 0);
        repeat (6) step();
        check("t6_acks", ack_cnt[0] - base, 1);
        wait_drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
